// File: rtl/jpeg_zigzag_pkg.sv
// Shared constants for the forward zigzag stage: block geometry and the
// JPEG zigzag scan table (raster position r*8+c for each scan index k).
package jpeg_zigzag_pkg;

  localparam int BLK_N = 8;
  localparam int NCOEF = 64;

  // The decoder-side inverse mapping is derived from this same table.
  localparam logic [5:0] ZZ_POS [0:NCOEF-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic is_last_idx(input logic [5:0] k);
    return k == 6'(NCOEF - 1);
  endfunction

endpackage

// File: rtl/zz_pingpong_buf.sv
// Two 64-entry coefficient banks: row-wide write port, single-element read port.
// Contents are intentionally not reset.
module zz_pingpong_buf
  import jpeg_zigzag_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      wr_bank,
  input  logic [2:0]                wr_row,
  input  logic [BLK_N*DATA_W-1:0]   wr_data,
  input  logic                      rd_bank,
  input  logic [5:0]                rd_pos,
  output logic [DATA_W-1:0]         rd_data
);

  logic [DATA_W-1:0] mem0 [0:NCOEF-1];
  logic [DATA_W-1:0] mem1 [0:NCOEF-1];

  // Column 0 sits in the MSB slice of the row word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < BLK_N; c++) begin
        if (wr_bank)
          mem1[{wr_row, 3'(c)}] <= wr_data[BLK_N*DATA_W-1-c*DATA_W -: DATA_W];
        else
          mem0[{wr_row, 3'(c)}] <= wr_data[BLK_N*DATA_W-1-c*DATA_W -: DATA_W];
      end
    end
  end

  assign rd_data = rd_bank ? mem1[rd_pos] : mem0[rd_pos];

endmodule

// File: rtl/zigzag_reorder.sv
// Forward zigzag reorder: loads 8x8 blocks row by row into a ping-pong buffer
// and streams coefficients in JPEG zigzag order through one output register.
module zigzag_reorder
  import jpeg_zigzag_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BLK_N*DATA_W-1:0]   in_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [5:0]                out_index,
  output logic                      out_last
);

  logic [1:0]        full;
  logic              wr_bank;
  logic [2:0]        wr_row;
  logic              rd_bank;
  logic [5:0]        rd_idx;
  logic [5:0]        rd_pos;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              load;

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign rd_pos   = ZZ_POS[rd_idx];

  zz_pingpong_buf #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_row),
    .rd_bank (rd_bank),
    .rd_pos  (rd_pos),
    .rd_data (rd_data)
  );

  // Writer only sets a non-full bank, reader only clears a full one, so the
  // two flag updates below never target the same bit on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      wr_row    <= '0;
      rd_bank   <= 1'b0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_index <= rd_idx;
        out_last  <= is_last_idx(rd_idx);
        rd_idx    <= rd_idx + 6'd1;
        if (is_last_idx(rd_idx)) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Randomised bench for zigzag_reorder; expected streams come from a
// diagonal-walk zigzag model applied to each generated block.
module tb_zigzag_reorder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_row;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [5:0]  out_index;
  logic        out_last;

  int n_cmp  = 0;
  int n_fail = 0;

  int zz_r [64];
  int zz_c [64];

  logic [63:0] row_q [$];
  logic [7:0]  exp_d [$];
  int          exp_k [$];
  int          beat_t [$];

  zigzag_reorder #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk anti-diagonals s=r+c; even diagonals go up-right, odd go down-left.
  task automatic init_zz();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_r[k] = r; zz_c[k] = s - r; k++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_r[k] = r; zz_c[k] = s - r; k++;
        end
      end
    end
  endtask

  // mode 0: r*8+c+base, 1: constant 0x7F, 2: checkerboard, 3: random
  task automatic push_block(input int mode, input int base);
    logic [7:0]  blk [8][8];
    logic [63:0] rw;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (mode)
          0: blk[r][c] = 8'((r * 8 + c + base) % 256);
          1: blk[r][c] = 8'h7F;
          2: blk[r][c] = ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
          default: blk[r][c] = 8'($urandom_range(0, 255));
        endcase
      end
    end
    for (int r = 0; r < 8; r++) begin
      rw = '0;
      for (int c = 0; c < 8; c++) rw = (rw << 8) | 64'(blk[r][c]);
      row_q.push_back(rw);
    end
    for (int k = 0; k < 64; k++) begin
      exp_d.push_back(blk[zz_r[k]][zz_c[k]]);
      exp_k.push_back(k);
    end
  endtask

  task automatic write_rows(input int n);
    logic [63:0] rw;
    int w;
    for (int i = 0; i < n; i++) begin
      rw = row_q.pop_front();
      in_valid = 1'b1;
      in_row   = rw;
      w = 0;
      while (!in_ready && w < 3000) begin
        step();
        w++;
      end
      if (w >= 3000) begin
        n_cmp++; n_fail++;
        $display("FAIL write_timeout: row %0d never accepted, in_ready=%b required 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      in_row   = {$urandom, $urandom};
    end
  endtask

  task automatic run_drain(input int nbeats, input bit bp, input bit chk_ready);
    int got;
    int t;
    bit held;
    logic [7:0] hd;
    logic [5:0] hk;
    logic [7:0] ed;
    int ek;
    got = 0; t = 0; held = 0; hd = '0; hk = '0;
    beat_t.delete();
    while (got < nbeats && t < 20000) begin
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (held) begin
        n_cmp++;
        if ({out_valid, out_data, out_index} !== {1'b1, hd, hk}) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%0d idx=%0d required valid=1 data=%0d idx=%0d",
                   out_valid, out_data, out_index, hd, hk);
        end
      end
      if (out_valid && out_ready) begin
        if (chk_ready && (got == 62 || got == 63)) begin
          n_cmp++;
          if (in_ready !== (got == 63)) begin
            n_fail++;
            $display("FAIL stall_ready: beat %0d in_ready=%b required %b", got, in_ready, got == 63);
          end
        end
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: data=%0d idx=%0d required no beat", out_data, out_index);
        end else begin
          ed = exp_d.pop_front();
          ek = exp_k.pop_front();
          if (out_data !== ed || out_index !== 6'(ek) || out_last !== (ek == 63)) begin
            n_fail++;
            $display("FAIL beat %0d: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                     got, out_data, out_index, out_last, ed, ek, ek == 63);
          end
        end
        beat_t.push_back(t);
        got++;
      end
      held = out_valid && !out_ready;
      hd = out_data;
      hk = out_index;
      step();
      t++;
    end
    out_ready = 1'b0;
    if (got < nbeats) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d beats required %0d", got, nbeats);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    #2;
    n_cmp++;
    if ({out_valid, out_data, out_index, out_last, in_ready} !== {1'b0, 8'd0, 6'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b data=%0d idx=%0d last=%b rdy=%b required 0 0 0 0 1",
               out_valid, out_data, out_index, out_last, in_ready);
    end
    #20 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single_block();
    push_block(0, 0);
    out_ready = 1'b1;
    write_rows(8);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%b after row7 edge required 0", out_valid);
    end
    run_drain(64, 1'b0, 1'b0);
    n_cmp++;
    if (beat_t.size() != 64 || beat_t[0] != 1 || beat_t[63] != 64) begin
      n_fail++;
      $display("FAIL latency: first beat at %0d last at %0d required 1 and 64",
               beat_t.size() > 0 ? beat_t[0] : -1, beat_t.size() == 64 ? beat_t[63] : -1);
    end
  endtask

  task automatic test_backpressure();
    push_block(0, 0);
    write_rows(8);
    run_drain(64, 1'b1, 1'b0);
  endtask

  task automatic test_ping_pong();
    push_block(0, 0);
    push_block(0, 64);
    fork
      write_rows(16);
      run_drain(128, 1'b0, 1'b0);
    join
    n_cmp++;
    if (beat_t.size() != 128 || beat_t[64] - beat_t[63] != 1) begin
      n_fail++;
      $display("FAIL pingpong_gap: gap between beat 63 and 64 is %0d required 1",
               beat_t.size() == 128 ? beat_t[64] - beat_t[63] : -1);
    end
  endtask

  task automatic test_full_stall();
    out_ready = 1'b0;
    push_block(0, 0);
    push_block(0, 64);
    push_block(3, 0);
    write_rows(16);
    in_valid = 1'b1;
    in_row   = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL both_full: in_ready=%b required 0", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_index !== 6'd0 || out_data !== 8'd0) begin
      n_fail++;
      $display("FAIL stalled_head: valid=%b idx=%0d data=%0d required 1 0 0", out_valid, out_index, out_data);
    end
    fork
      write_rows(8);
      run_drain(192, 1'b0, 1'b1);
    join
  endtask

  task automatic test_reset_mid();
    push_block(3, 0);
    write_rows(3);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_index, out_last, in_ready} !== {1'b0, 8'd0, 6'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_partial: valid=%b data=%0d idx=%0d last=%b rdy=%b required 0 0 0 0 1",
               out_valid, out_data, out_index, out_last, in_ready);
    end
    #2 rst_n = 1'b1;
    row_q.delete(); exp_d.delete(); exp_k.delete();
    step();
    push_block(3, 0);
    write_rows(8);
    run_drain(64, 1'b1, 1'b0);

    push_block(0, 5);
    write_rows(8);
    run_drain(20, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_index, out_last, in_ready} !== {1'b0, 8'd0, 6'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_drain: valid=%b data=%0d idx=%0d last=%b rdy=%b required 0 0 0 0 1",
               out_valid, out_data, out_index, out_last, in_ready);
    end
    #2 rst_n = 1'b1;
    row_q.delete(); exp_d.delete(); exp_k.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: out_valid=%b cycle %0d required 0", out_valid, i);
      end
    end
    out_ready = 1'b0;
    push_block(0, 200);
    write_rows(8);
    run_drain(64, 1'b1, 1'b0);
  endtask

  task automatic test_random_blocks();
    push_block(1, 0);
    push_block(2, 0);
    for (int b = 2; b < 100; b++) push_block(3, 0);
    fork
      write_rows(800);
      run_drain(6400, 1'b1, 1'b0);
    join
    n_cmp++;
    if (exp_d.size() != 0) begin
      n_fail++;
      $display("FAIL random_leftover: %0d expected beats unconsumed required 0", exp_d.size());
    end
  endtask

  initial begin
    init_zz();
    test_reset();
    test_single_block();
    test_backpressure();
    test_ping_pong();
    test_full_stall();
    test_reset_mid();
    test_random_blocks();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
